// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write controller.
// The state set depends on the REGFILE_DUMP_EN build option.
package regfile_ctrl_pkg;

    localparam int REG_SIZE_DEF = 32;
    localparam int REG_NUM_DEF  = 32;

`ifdef REGFILE_DUMP_EN
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_DUMP  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;
`endif

    // Address width for a register file of n entries (at least one bit)
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_counter.sv
// Wrapping address counter with sync clear, enable and an all-ones
// terminal-count flag. Reset loads RST_VAL, clear loads zero.
module addr_counter #(
    parameter int            AW      = 5,
    parameter logic [AW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          tc
);

    // Clear takes priority over counting
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= RST_VAL;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + AW'(1);
    end

    assign tc = &cnt;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-channel controller for a reset-less register file.
// After reset it zeroes registers 1..REG_NUM-1, then forwards core
// writebacks to the write port with one cycle of latency.
// Build option REGFILE_DUMP_EN adds a dump engine that walks the read port
// and streams every register out over a valid/ready channel.
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter  int REG_SIZE = REG_SIZE_DEF,
    parameter  int REG_NUM  = REG_NUM_DEF,
    localparam int AW       = addr_width(REG_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [AW-1:0]       wb_addr,
    input  logic [REG_SIZE-1:0] wb_data,
    output logic                rf_wr_ena,
    output logic [AW-1:0]       rf_wr_addr,
    output logic [REG_SIZE-1:0] rf_wr_data
`ifdef REGFILE_DUMP_EN
    ,
    input  logic                dump_start,
    output logic                dump_busy,
    output logic [AW-1:0]       rf_rd_addr,
    input  logic [REG_SIZE-1:0] rf_rd_data,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_addr,
    output logic [REG_SIZE-1:0] dump_data
`endif
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          cnt_tc;
    logic          cnt_clr;
    logic          cnt_en;
    logic          wb_fire;

`ifdef REGFILE_DUMP_EN
    logic          dump_last;   // beat REG_NUM-1 is already in the output register
    logic          dump_load;

    // Refill the beat register when it is empty or being drained this cycle
    assign dump_load  = (state == S_DUMP) && !dump_last && (!dump_valid || dump_ready);
    assign dump_busy  = (state == S_DUMP);
    assign rf_rd_addr = (state == S_DUMP) ? cnt : '0;
    assign init_done  = (state == S_RUN) || (state == S_DUMP);
`else
    assign init_done  = (state == S_RUN);
`endif

    assign wb_ready = (state == S_RUN);
    assign wb_fire  = wb_valid && wb_ready;

    // One counter serves both the clear sweep (starts at 1) and the dump walk (starts at 0)
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (state == S_CLEAR)
            cnt_en = 1'b1;
`ifdef REGFILE_DUMP_EN
        else if (state == S_RUN)
            cnt_clr = dump_start;
        else if (state == S_DUMP)
            cnt_en = dump_load;
`endif
    end

    addr_counter #(
        .AW      (AW),
        .RST_VAL (AW'(1))
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // Control FSM with registered write-port and dump-beat outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            rf_wr_ena  <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
`ifdef REGFILE_DUMP_EN
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
`endif
        end else begin
            case (state)
                S_CLEAR: begin
                    rf_wr_ena  <= 1'b1;
                    rf_wr_addr <= cnt;
                    rf_wr_data <= '0;
                    if (cnt_tc)
                        state <= S_RUN;
                end
                S_RUN: begin
                    // Writes to register 0 are accepted but never reach the port
                    rf_wr_ena <= wb_fire && (wb_addr != '0);
                    if (wb_fire) begin
                        rf_wr_addr <= wb_addr;
                        rf_wr_data <= wb_data;
                    end
`ifdef REGFILE_DUMP_EN
                    // A same-cycle writeback lands at the next edge, before
                    // the walk reaches its register
                    if (dump_start)
                        state <= S_DUMP;
`endif
                end
`ifdef REGFILE_DUMP_EN
                S_DUMP: begin
                    rf_wr_ena <= 1'b0;
                    if (dump_load) begin
                        dump_valid <= 1'b1;
                        dump_addr  <= cnt;
                        dump_data  <= rf_rd_data;
                        if (cnt_tc)
                            dump_last <= 1'b1;
                    end else if (dump_valid && dump_ready && dump_last) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        state      <= S_RUN;
                    end
                end
`endif
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule
